// File: rtl/frame_decoder24_if.sv
// frame_decoder24_if
//  Bundles the codeword input handshake, the decoded-nibble output handshake
//  and the per-frame status signals of the SECDED(8,4) frame decoder.
//  master : the frame source and result sink (drives start, in_*, out_ready)
//  slave  : the decoder (drives in_ready, out_*, counters, busy, frame_done)
//  Signals:
//   start       1      begin a frame (honoured when idle)
//   in_valid    1      codeword valid
//   in_data     8      codeword {p0,d4,d3,d2,p4,d1,p2,p1}
//   in_ready    1      decoder accepts in_data this cycle
//   out_valid   1      decoded nibble valid
//   out_data    4      {d4,d3,d2,d1}
//   out_corr    1      single error corrected on this beat
//   out_dbl     1      uncorrectable double error on this beat
//   out_last    1      last codeword of the frame
//   out_ready   1      sink accepts the output beat
//   cnt         CNT_W  codewords accepted in the current frame
//   corr_total  CNT_W  corrected beats in the current/last frame
//   dbl_total   CNT_W  double-error beats in the current/last frame
//   busy        1      decoder not idle
//   frame_done  1      one-cycle pulse at frame end
interface frame_decoder24_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       out_data;
    logic             out_corr;
    logic             out_dbl;
    logic             out_last;
    logic             out_ready;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] corr_total;
    logic [CNT_W-1:0] dbl_total;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_corr, out_dbl, out_last,
               cnt, corr_total, dbl_total, busy, frame_done
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_corr, out_dbl, out_last,
               cnt, corr_total, dbl_total, busy, frame_done
    );
endinterface

// File: rtl/frame_decoder24.sv
// frame_decoder24
//  Receive-side SECDED(8,4) decoder. Accepts FRAME_LEN codewords per frame,
//  corrects single-bit errors, flags double-bit errors, and keeps per-frame
//  beat / correction / double-error counts. frame_done pulses for one cycle
//  after the last decoded beat has been taken downstream.
//  Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   frame_decoder24_if.slave (handshakes, counters, status)
module frame_decoder24 #(
    parameter int FRAME_LEN = 24,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    frame_decoder24_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic             in_ready_c;
    logic             busy_c;
    logic             frame_done_c;
    logic             accept;
    logic             out_take;

    logic             out_valid_reg;
    logic [3:0]       out_data_reg;
    logic             out_corr_reg;
    logic             out_dbl_reg;
    logic             out_last_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] corr_total_reg;
    logic [CNT_W-1:0] dbl_total_reg;

    // ---------------- decode ----------------
    logic [7:0] cw;
    logic [2:0] syn;
    logic       pe;
    logic [6:0] flip_mask;
    logic [6:0] fixed;
    logic [3:0] dec_data;
    logic       dec_corr;
    logic       dec_dbl;

    assign cw  = bus.in_data;
    assign syn = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                  cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                  cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    assign pe  = ^cw;

    // One-hot flip of c[S-1] on a single error. S==0 with odd parity means
    // p0 itself was hit, so no bit of c[6:0] is touched.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_flip
            assign flip_mask[gi] = pe && (syn == 3'(gi + 1));
        end
    endgenerate

    assign fixed    = cw[6:0] ^ flip_mask;
    assign dec_data = {fixed[6], fixed[5], fixed[4], fixed[2]};
    assign dec_corr = pe;
    assign dec_dbl  = !pe && (syn != 3'd0);

    assign accept   = bus.in_valid && in_ready_c;
    assign out_take = out_valid_reg && bus.out_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.start) state_next = RUN;
            RUN:   if (accept && (cnt_reg == CNT_W'(FRAME_LEN - 1))) state_next = DRAIN;
            DRAIN: if (out_take && out_last_reg) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c   = (state_reg == RUN) && (!out_valid_reg || bus.out_ready);
        busy_c       = (state_reg != IDLE);
        frame_done_c = (state_reg == DONE);
    end

    // ---------------- output stage and counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_corr_reg   <= 1'b0;
            out_dbl_reg    <= 1'b0;
            out_last_reg   <= 1'b0;
            cnt_reg        <= '0;
            corr_total_reg <= '0;
            dbl_total_reg  <= '0;
        end else begin
            if (state_reg == IDLE && bus.start) begin
                cnt_reg        <= '0;
                corr_total_reg <= '0;
                dbl_total_reg  <= '0;
            end

            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= dec_data;
                out_corr_reg  <= dec_corr;
                out_dbl_reg   <= dec_dbl;
                out_last_reg  <= (cnt_reg == CNT_W'(FRAME_LEN - 1));
                // Saturating guards keep the counters from wrapping even if
                // the frame bookkeeping were ever upset.
                if (cnt_reg != CNT_W'(FRAME_LEN)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                if (dec_corr && corr_total_reg != CNT_W'(FRAME_LEN)) begin
                    corr_total_reg <= corr_total_reg + 1'b1;
                end
                if (dec_dbl && dbl_total_reg != CNT_W'(FRAME_LEN)) begin
                    dbl_total_reg <= dbl_total_reg + 1'b1;
                end
            end else if (out_take) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.busy       = busy_c;
    assign bus.frame_done = frame_done_c;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.out_corr   = out_corr_reg;
    assign bus.out_dbl    = out_dbl_reg;
    assign bus.out_last   = out_last_reg;
    assign bus.cnt        = cnt_reg;
    assign bus.corr_total = corr_total_reg;
    assign bus.dbl_total  = dbl_total_reg;

endmodule

// File: tb/tb_frame_decoder24.sv
// tb_frame_decoder24
//  Directed bench for frame_decoder24. Expected beats are pushed to a queue
//  when a codeword is accepted and popped/compared when the output handshakes.
module tb_frame_decoder24;

    localparam int FRAME_LEN = 24;
    localparam int CNT_W     = 5;

    logic clk;
    logic rst;

    frame_decoder24_if #(.CNT_W(CNT_W)) bus ();

    frame_decoder24 #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] d;
        logic       c;
        logic       b;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   beats  = 0;
    int   cyc    = 0;
    int   last_hs_cyc = -10;
    int   ready_mode  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        return {^c, c};
    endfunction

    // out_ready driver: 0 = always ready, 1 = toggling, other = random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor / scoreboard pop, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("beat %0d data=%h corr=%b dbl=%b last=%b", beats,
                         bus.out_data, bus.out_corr, bus.out_dbl, bus.out_last);
                check("out_data", 32'(bus.out_data), 32'(e.d));
                check("out_corr", 32'(bus.out_corr), 32'(e.c));
                check("out_dbl",  32'(bus.out_dbl),  32'(e.b));
                check("out_last", 32'(bus.out_last), 32'(e.l));
            end
            beats++;
            if (bus.out_last) last_hs_cyc = cyc;
        end
        if (!rst && bus.out_valid && !bus.out_ready) begin
            check("in_ready_stalled", 32'(bus.in_ready), 32'd0);
        end
        if (!rst && bus.frame_done) begin
            check("frame_done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] cw, input logic [3:0] ed,
                        input logic ec, input logic eb, input logic el);
        bit done = 0;
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = cw;
        while (!done && t < 100) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{d: ed, c: ec, b: eb, l: el});
                done = 1;
            end
            tick();
            t++;
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1;
            tick();
        end
        check("frame_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("frame_done_pulse", 32'(bus.frame_done), 32'd0);
        check("busy_after_frame", 32'(bus.busy), 32'd0);
        tick();
    endtask

    task automatic frame_end_checks(input int ecorr, input int edbl);
        check("cnt_final",   32'(bus.cnt), 32'(FRAME_LEN));
        check("corr_total",  32'(bus.corr_total), 32'(ecorr));
        check("dbl_total",   32'(bus.dbl_total), 32'(edbl));
        check("beat_count",  32'(beats), 32'(FRAME_LEN));
        check("sb_empty",    32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] d;
        logic [7:0] cw;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid",  32'(bus.out_valid), 32'd0);
        check("rst_in_ready",   32'(bus.in_ready), 32'd0);
        check("rst_busy",       32'(bus.busy), 32'd0);
        check("rst_cnt",        32'(bus.cnt), 32'd0);
        check("rst_corr_total", 32'(bus.corr_total), 32'd0);
        check("rst_dbl_total",  32'(bus.dbl_total), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);

        // Frame 1: clean codewords, data = i % 16, always ready
        ready_mode = 0;
        beats = 0;
        pulse_start();
        check("busy_in_run", 32'(bus.busy), 32'd1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            d = 4'(i % 16);
            send(enc(d), d, 1'b0, 1'b0, i == FRAME_LEN - 1);
        end
        wait_done();
        frame_end_checks(0, 0);

        // Frame 2: two single errors and one double error, rest clean
        beats = 0;
        pulse_start();
        cw = enc(4'hA) ^ 8'h20;
        send(cw, 4'hA, 1'b1, 1'b0, 1'b0);
        cw = enc(4'hA) ^ 8'h80;
        send(cw, 4'hA, 1'b1, 1'b0, 1'b0);
        cw = enc(4'hA) ^ 8'h14;
        send(cw, 4'h9, 1'b0, 1'b1, 1'b0);
        for (int i = 3; i < FRAME_LEN; i++) begin
            d = 4'($urandom_range(0, 15));
            send(enc(d), d, 1'b0, 1'b0, i == FRAME_LEN - 1);
        end
        wait_done();
        frame_end_checks(2, 1);

        // IDLE: in_valid must be ignored and counters held
        bus.in_valid = 1'b1;
        bus.in_data  = enc(4'h3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("idle_cnt_hold",  32'(bus.cnt), 32'(FRAME_LEN));
        check("idle_corr_hold", 32'(bus.corr_total), 32'd2);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Frame 3: toggling out_ready, start pulsed during RUN and at the tail
        ready_mode = 1;
        beats = 0;
        pulse_start();
        for (int i = 0; i < FRAME_LEN; i++) begin
            d = 4'($urandom_range(0, 15));
            send(enc(d), d, 1'b0, 1'b0, i == FRAME_LEN - 1);
            if (i == 5) begin
                pulse_start();
                check("start_in_run_cnt", 32'(bus.cnt), 32'd6);
            end
        end
        pulse_start();
        wait_done();
        frame_end_checks(0, 0);

        // Frame 4: reset after 10 beats aborts the frame
        ready_mode = 0;
        beats = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            d = 4'(15 - i);
            send(enc(d), d, 1'b0, 1'b0, 1'b0);
        end
        pulse_start();
        check("start_ignored_cnt", 32'(bus.cnt), 32'd10);
        check("start_ignored_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_cnt",       32'(bus.cnt), 32'd0);
        check("abort_busy",      32'(bus.busy), 32'd0);
        check("abort_out_data",  32'(bus.out_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.frame_done), 32'd0);
            tick();
        end

        // Frame 5: full frame after abort, random backpressure
        ready_mode = 2;
        beats = 0;
        pulse_start();
        check("restart_cnt", 32'(bus.cnt), 32'd0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            d = 4'($urandom_range(0, 15));
            send(enc(d), d, 1'b0, 1'b0, i == FRAME_LEN - 1);
        end
        wait_done();
        frame_end_checks(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
